// File: rtl/rom_fetch_seq_pkg.sv
// Shared types and defaults for the ROM fetch sequencer.
package rom_fetch_seq_pkg;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 32;

  // Encodings are fixed so that state can be compared against external traces.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/rom_fetch_seq_if.sv
// Word-pair output stream with valid/ready handshake.
interface rom_fetch_seq_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W-1:0] dato_a;
  logic [DATA_W-1:0] dato_b;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output dato_a,
    output dato_b,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  dato_a,
    input  dato_b,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/rom_fetch_seq.sv
// Address sequencer and output register stage for a dual-read ROM.
// Reads ptr and ptr+1 each load and streams the registered pair downstream.
module rom_fetch_seq
  import rom_fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] Dir1,
  output logic [ADDR_W-1:0] Dir2,
  input  logic [DATA_W-1:0] DatoL1,
  input  logic [DATA_W-1:0] DatoL2,
  output logic              busy,
  output logic              done,
  rom_fetch_seq_if.master   out_if
);

  localparam logic [ADDR_W:0] RemainOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [DATA_W-1:0] dato_a_q, dato_a_d;
  logic [DATA_W-1:0] dato_b_q, dato_b_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              load;

  // Output slot is free when empty or being consumed this cycle.
  assign load = (state_q == StRun) && (!valid_q || out_if.out_ready);

  // Next-state, pointer and output-register update.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A zero-length burst completes immediately without leaving idle.
        if (start) begin
          if (count != '0) begin
            ptr_d    = base_addr;
            remain_d = count;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (load) begin
          dato_a_d = DatoL1;
          dato_b_d = DatoL2;
          valid_d  = 1'b1;
          ptr_d    = ptr_q + ADDR_W'(2);
          remain_d = remain_q - RemainOne;
          if (remain_q == RemainOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (!valid_q || out_if.out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      remain_q <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign Dir1             = ptr_q;
  assign Dir2             = ptr_q + 1'b1;
  assign busy             = (state_q != StIdle);
  assign done             = done_q;
  assign out_if.dato_a    = dato_a_q;
  assign out_if.dato_b    = dato_b_q;
  assign out_if.out_valid = valid_q;

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Directed bench for rom_fetch_seq with an inline ROM holding A000_0000 | addr.
module tb_rom_fetch_seq;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] Dir1;
  logic [AW-1:0] Dir2;
  logic [DW-1:0] DatoL1;
  logic [DW-1:0] DatoL2;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fails  = 0;
  int hist [16];

  rom_fetch_seq_if #(.DATA_W(DW)) bus ();

  rom_fetch_seq #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .count    (count),
    .Dir1     (Dir1),
    .Dir2     (Dir2),
    .DatoL1   (DatoL1),
    .DatoL2   (DatoL2),
    .busy     (busy),
    .done     (done),
    .out_if   (bus)
  );

  // ROM model: combinational dual read.
  assign DatoL1 = 32'hA000_0000 | {28'h0, Dir1};
  assign DatoL2 = 32'hA000_0000 | {28'h0, Dir2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int a);
    return 32'hA000_0000 | (a & 15);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pair(input string tag, input int a);
    chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " dato_a"}, 64'(bus.dato_a), 64'(rom(a)));
    chk({tag, " dato_b"}, 64'(bus.dato_b), 64'(rom(a + 1)));
  endtask

  task automatic issue(input int b, input int c);
    start     = 1'b1;
    base_addr = AW'(b);
    count     = (AW + 1)'(c);
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    base_addr    = '0;
    count        = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst Dir1", 64'(Dir1), 64'd0);
    chk("rst Dir2", 64'(Dir2), 64'd1);
    chk("rst valid", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dato_a", 64'(bus.dato_a), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Basic burst
    issue(0, 3);
    chk("b1 busy", 64'(busy), 64'd1);
    chk("b1 Dir1", 64'(Dir1), 64'd0);
    chk("b1 valid0", 64'(bus.out_valid), 64'd0);
    tick(); chk_pair("b1 p0", 0);
    chk("b1 Dir1 adv", 64'(Dir1), 64'd2);
    tick(); chk_pair("b1 p1", 2);
    tick(); chk_pair("b1 p2", 4);
    chk("b1 done early", 64'(done), 64'd0);
    tick();
    chk("b1 done", 64'(done), 64'd1);
    chk("b1 busy end", 64'(busy), 64'd0);
    chk("b1 valid end", 64'(bus.out_valid), 64'd0);
    tick();
    chk("b1 done pulse", 64'(done), 64'd0);

    // 2. Wrap
    issue(14, 2);
    chk("w Dir2", 64'(Dir2), 64'd15);
    tick(); chk_pair("w p0", 14);
    chk("w Dir1 wrap", 64'(Dir1), 64'd0);
    tick(); chk_pair("w p1", 0);
    tick(); chk("w done", 64'(done), 64'd1);
    tick();
    issue(15, 1);
    chk("w15 Dir2", 64'(Dir2), 64'd0);
    tick(); chk_pair("w15 p0", 15);
    tick(); chk("w15 done", 64'(done), 64'd1);
    tick();

    // 3. Backpressure, ready pattern 1,0,0,1 repeating
    issue(3, 4);
    tick(); chk_pair("bp p0", 3);
    bus.out_ready = 1'b1; tick(); chk_pair("bp p1", 5);
    bus.out_ready = 1'b0; tick(); chk_pair("bp p1 hold", 5);
    bus.out_ready = 1'b0; tick(); chk_pair("bp p1 hold2", 5);
    bus.out_ready = 1'b1; tick(); chk_pair("bp p2", 7);
    bus.out_ready = 1'b1; tick(); chk_pair("bp p3", 9);
    bus.out_ready = 1'b0; tick(); chk_pair("bp p3 hold", 9);
    chk("bp drain busy", 64'(busy), 64'd1);
    bus.out_ready = 1'b0; tick(); chk_pair("bp p3 hold2", 9);
    chk("bp no done", 64'(done), 64'd0);
    bus.out_ready = 1'b1; tick();
    chk("bp done", 64'(done), 64'd1);
    chk("bp valid end", 64'(bus.out_valid), 64'd0);
    tick();

    // 4. Zero count, then start ignored during RUN
    issue(7, 0);
    chk("z done", 64'(done), 64'd1);
    chk("z busy", 64'(busy), 64'd0);
    tick();
    chk("z done pulse", 64'(done), 64'd0);
    issue(8, 3);
    start = 1'b1; base_addr = 4'd0; count = 5'd5;
    tick(); start = 1'b0;
    chk_pair("ig p0", 8);
    chk("ig Dir1", 64'(Dir1), 64'd10);
    tick(); chk_pair("ig p1", 10);
    tick(); chk_pair("ig p2", 12);
    tick(); chk("ig done", 64'(done), 64'd1);
    tick();

    // 5a. Abort after second handshake
    issue(0, 6);
    tick(); chk_pair("ab p0", 0);
    tick(); chk_pair("ab p1", 2);
    tick(); chk_pair("ab p2", 4);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab busy", 64'(busy), 64'd0);
    chk("ab valid", 64'(bus.out_valid), 64'd0);
    chk("ab done", 64'(done), 64'd0);
    tick();
    chk("ab done late", 64'(done), 64'd0);
    // Abort coincident with start in idle is ignored.
    abort = 1'b1;
    issue(2, 1);
    abort = 1'b0;
    chk("abs busy", 64'(busy), 64'd1);
    tick(); chk_pair("abs p0", 2);
    tick(); chk("abs done", 64'(done), 64'd1);
    tick();

    // 5b. Asynchronous reset mid-burst
    issue(4, 5);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar valid", 64'(bus.out_valid), 64'd0);
    chk("ar busy", 64'(busy), 64'd0);
    chk("ar Dir1", 64'(Dir1), 64'd0);
    chk("ar Dir2", 64'(Dir2), 64'd1);
    chk("ar dato_b", 64'(bus.dato_b), 64'd0);
    tick();
    chk("ar done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // 6. Full depth
    for (int i = 0; i < 16; i++) hist[i] = 0;
    issue(5, 16);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_pair("fd pair", 5 + 2 * i);
      hist[bus.dato_a[3:0]]++;
      hist[bus.dato_b[3:0]]++;
    end
    chk("fd no done", 64'(done), 64'd0);
    tick();
    chk("fd done", 64'(done), 64'd1);
    for (int i = 0; i < 16; i++) chk("fd coverage", 64'(hist[i]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
